// File: rtl/mem_wb_hilo_pkg.sv
// Shared constants and helpers for the MEM/WB stage and the HI/LO register.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mem_wb_hilo_pkg;

  // Control-level encodings used across the core
  localparam logic RstEnable    = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic Stop         = 1'b1;
  localparam logic NoStop       = 1'b0;

  // Datapath widths
  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam logic [RegBus-1:0]     ZeroWord   = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

  // What the WB pipeline register does at the next edge
  typedef enum logic [1:0] {
    WB_CLEAR   = 2'd0,  // reset or flush: kill everything in flight
    WB_BUBBLE  = 2'd1,  // MEM held but WB free: WB must not repeat the old op
    WB_CAPTURE = 2'd2,  // MEM advances into WB
    WB_HOLD    = 2'd3   // MEM and WB both held
  } wb_upd_e;

  // Priority: reset, flush (beats any stall), bubble, capture, hold.
  function automatic wb_upd_e wb_action(input logic rst, input logic flush,
                                        input logic mem_stall, input logic wb_stall);
    wb_upd_e act;
    if (rst == RstEnable)                                act = WB_CLEAR;
    else if (flush)                                      act = WB_CLEAR;
    else if (mem_stall == Stop && wb_stall == NoStop)    act = WB_BUBBLE;
    else if (mem_stall == NoStop)                        act = WB_CAPTURE;
    else                                                 act = WB_HOLD;
    return act;
  endfunction

endpackage

// File: rtl/mem_wb_hilo_hilo_reg.sv
// Architectural HI/LO register pair; storage only, no bypass.
// Latency: write visible on hi_o/lo_o one cycle after the edge that samples we.
// Backpressure: none; a repeated identical write while WB is held is harmless.
module hilo_reg
  import mem_wb_hilo_pkg::*;
#(
  parameter int DATA_W = RegBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  // Clear on reset, otherwise commit the WB-stage HI/LO result when enabled
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      hi_o <= DATA_W'(ZeroWord);
      lo_o <= DATA_W'(ZeroWord);
    end else if (we == WriteEnable) begin
      hi_o <= hi_i;
      lo_o <= lo_i;
    end
  end

endmodule

// File: rtl/mem_wb_hilo.sv
// MEM/WB pipeline register driving the GPR write port, plus HI/LO ownership with WB bypass.
// Latency: mem_* to wb_* is one cycle; HI/LO is architectural one cycle after WB.
// Backpressure: honours the stall vector (bubble when MEM held and WB free, hold when both held); flush wins.
module mem_wb_hilo
  import mem_wb_hilo_pkg::*;
#(
  parameter int DATA_W  = RegBus,
  parameter int ADDR_W  = RegAddrBus,
  parameter int STALL_W = 6,
  parameter int MEM_BIT = 4,
  parameter int WB_BIT  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  mem_wd,
  input  logic               mem_wreg,
  input  logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_whilo,
  input  logic [DATA_W-1:0]  mem_hi,
  input  logic [DATA_W-1:0]  mem_lo,
  output logic [ADDR_W-1:0]  wb_wd,
  output logic               wb_wreg,
  output logic [DATA_W-1:0]  wb_wdata,
  output logic [DATA_W-1:0]  hi_o,
  output logic [DATA_W-1:0]  lo_o
);

  // WB-stage HI/LO payload, not exported
  logic              wb_whilo;
  logic [DATA_W-1:0] wb_hi;
  logic [DATA_W-1:0] wb_lo;

  // Architectural HI/LO
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  wb_upd_e upd;

  // Only the MEM and WB bits of the stall vector matter here
  logic unused_stall;
  assign unused_stall = ^stall;

  // Decide this edge's pipeline-register action
  always_comb begin
    upd = wb_action(rst, flush, stall[MEM_BIT], stall[WB_BIT]);
  end

  // MEM/WB register; $0 writes are dropped here so the regfile never sees them
  always_ff @(posedge clk) begin
    case (upd)
      WB_CLEAR, WB_BUBBLE: begin
        wb_wd    <= ADDR_W'(NOPRegAddr);
        wb_wreg  <= WriteDisable;
        wb_wdata <= DATA_W'(ZeroWord);
        wb_whilo <= WriteDisable;
        wb_hi    <= DATA_W'(ZeroWord);
        wb_lo    <= DATA_W'(ZeroWord);
      end
      WB_CAPTURE: begin
        wb_wd    <= mem_wd;
        wb_wreg  <= mem_wreg && (mem_wd != ADDR_W'(NOPRegAddr));
        wb_wdata <= mem_wdata;
        wb_whilo <= mem_whilo;
        wb_hi    <= mem_hi;
        wb_lo    <= mem_lo;
      end
      default: begin
        wb_wd    <= wb_wd;
        wb_wreg  <= wb_wreg;
        wb_wdata <= wb_wdata;
        wb_whilo <= wb_whilo;
        wb_hi    <= wb_hi;
        wb_lo    <= wb_lo;
      end
    endcase
  end

  // HI/LO commits straight from WB; deliberately not gated by the WB stall bit
  hilo_reg #(
    .DATA_W (DATA_W)
  ) u_hilo_reg (
    .clk  (clk),
    .rst  (rst),
    .we   (wb_whilo),
    .hi_i (wb_hi),
    .lo_i (wb_lo),
    .hi_o (hi_q),
    .lo_o (lo_q)
  );

  // EX sees an in-flight WB HI/LO write a cycle before it becomes architectural
  always_comb begin
    if (wb_whilo == WriteEnable) begin
      hi_o = wb_hi;
      lo_o = wb_lo;
    end else begin
      hi_o = hi_q;
      lo_o = lo_q;
    end
  end

endmodule

// File: tb/tb_mem_wb_hilo.sv
// Bench for mem_wb_hilo: directed table, reset sequence, then random traffic vs a reference model.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: stall and flush patterns are driven directly.
module tb_mem_wb_hilo;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  mem_wb_hilo dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .mem_whilo (mem_whilo),
    .mem_hi    (mem_hi),
    .mem_lo    (mem_lo),
    .wb_wd     (wb_wd),
    .wb_wreg   (wb_wreg),
    .wb_wdata  (wb_wdata),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } instr_t;

  typedef struct {
    logic        rst;
    logic        flush;
    logic [5:0]  stall;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [31:0] e_wdata;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: the instruction sitting in WB and the architectural HI/LO
  instr_t in_wb;
  logic [31:0] arch_hi, arch_lo;

  localparam instr_t NOP = '{wd: 5'd0, wreg: 1'b0, wdata: 32'd0, whilo: 1'b0, hi: 32'd0, lo: 32'd0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // One clock edge of architectural behaviour
  task automatic model_edge(input logic r, input logic f, input logic [5:0] s, input instr_t in);
    instr_t nxt;
    if (r) begin
      arch_hi = 32'd0;
      arch_lo = 32'd0;
      in_wb   = NOP;
    end else begin
      if (in_wb.whilo) begin
        arch_hi = in_wb.hi;
        arch_lo = in_wb.lo;
      end
      nxt = in;
      if (in.wd == 5'd0) nxt.wreg = 1'b0;
      if (f)               in_wb = NOP;
      else if (!s[4])      in_wb = nxt;
      else if (!s[5])      in_wb = NOP;
    end
  endtask

  task automatic step(input logic r, input logic f, input logic [5:0] s, input instr_t in);
    rst = r; flush = f; stall = s;
    mem_wd = in.wd; mem_wreg = in.wreg; mem_wdata = in.wdata;
    mem_whilo = in.whilo; mem_hi = in.hi; mem_lo = in.lo;
    @(posedge clk);
    model_edge(r, f, s, in);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".wb_wd"},    {27'd0, wb_wd},   {27'd0, in_wb.wd});
    check({tag, ".wb_wreg"},  {31'd0, wb_wreg}, {31'd0, in_wb.wreg});
    check({tag, ".wb_wdata"}, wb_wdata,         in_wb.wdata);
    check({tag, ".hi_o"},     hi_o,             in_wb.whilo ? in_wb.hi : arch_hi);
    check({tag, ".lo_o"},     lo_o,             in_wb.whilo ? in_wb.lo : arch_lo);
  endtask

  function automatic instr_t rand_instr();
    instr_t t;
    t.wd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    t.wreg  = 1'($urandom);
    t.wdata = $urandom;
    t.whilo = ($urandom_range(0, 3) == 0);
    t.hi    = $urandom;
    t.lo    = $urandom;
    return t;
  endfunction

  vec_t tv [21];

  initial begin
    instr_t in;
    logic [5:0] s;

    rst = 1'b1; flush = 1'b0; stall = 6'd0;
    mem_wd = 5'd0; mem_wreg = 1'b0; mem_wdata = 32'd0;
    mem_whilo = 1'b0; mem_hi = 32'd0; mem_lo = 32'd0;
    arch_hi = 32'd0; arch_lo = 32'd0; in_wb = NOP;

    //                rst   flush stall      wd  wreg wdata         whilo hi     lo     e_wd e_wreg e_wdata       e_hi   e_lo
    tv[0]  = '{1'b0, 1'b0, 6'b000000, 5'd3,  1'b1, 32'h1234_5678, 1'b0, 32'h0,  32'h0,  5'd3,  1'b1, 32'h1234_5678, 32'h0,  32'h0};
    tv[1]  = '{1'b0, 1'b0, 6'b000000, 5'd0,  1'b0, 32'h0,         1'b0, 32'h0,  32'h0,  5'd0,  1'b0, 32'h0,         32'h0,  32'h0};
    tv[2]  = '{1'b0, 1'b0, 6'b000000, 5'd0,  1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0,  32'h0,  5'd0,  1'b0, 32'hFFFF_FFFF, 32'h0,  32'h0};
    tv[3]  = '{1'b0, 1'b0, 6'b000000, 5'd7,  1'b1, 32'h77,        1'b0, 32'h0,  32'h0,  5'd7,  1'b1, 32'h77,        32'h0,  32'h0};
    tv[4]  = '{1'b0, 1'b0, 6'b011111, 5'd9,  1'b1, 32'h99,        1'b0, 32'h0,  32'h0,  5'd0,  1'b0, 32'h0,         32'h0,  32'h0};
    tv[5]  = '{1'b0, 1'b0, 6'b000000, 5'd8,  1'b1, 32'h88,        1'b0, 32'h0,  32'h0,  5'd8,  1'b1, 32'h88,        32'h0,  32'h0};
    tv[6]  = '{1'b0, 1'b0, 6'b111111, 5'd10, 1'b1, 32'hAA,        1'b0, 32'h0,  32'h0,  5'd8,  1'b1, 32'h88,        32'h0,  32'h0};
    tv[7]  = '{1'b0, 1'b0, 6'b111111, 5'd10, 1'b1, 32'hAA,        1'b0, 32'h0,  32'h0,  5'd8,  1'b1, 32'h88,        32'h0,  32'h0};
    tv[8]  = '{1'b0, 1'b0, 6'b000000, 5'd10, 1'b1, 32'hAA,        1'b0, 32'h0,  32'h0,  5'd10, 1'b1, 32'hAA,        32'h0,  32'h0};
    tv[9]  = '{1'b0, 1'b0, 6'b000000, 5'd0,  1'b0, 32'h0,         1'b1, 32'hA,  32'hB,  5'd0,  1'b0, 32'h0,         32'hA,  32'hB};
    tv[10] = '{1'b0, 1'b0, 6'b000000, 5'd0,  1'b0, 32'h0,         1'b0, 32'h0,  32'h0,  5'd0,  1'b0, 32'h0,         32'hA,  32'hB};
    tv[11] = '{1'b0, 1'b0, 6'b000000, 5'd0,  1'b0, 32'h0,         1'b1, 32'hC,  32'hD,  5'd0,  1'b0, 32'h0,         32'hC,  32'hD};
    tv[12] = '{1'b0, 1'b0, 6'b000000, 5'd0,  1'b0, 32'h0,         1'b0, 32'h0,  32'h0,  5'd0,  1'b0, 32'h0,         32'hC,  32'hD};
    tv[13] = '{1'b0, 1'b1, 6'b000000, 5'd5,  1'b1, 32'h55,        1'b1, 32'hEE, 32'hFF, 5'd0,  1'b0, 32'h0,         32'hC,  32'hD};
    tv[14] = '{1'b0, 1'b0, 6'b000000, 5'd0,  1'b0, 32'h0,         1'b0, 32'h0,  32'h0,  5'd0,  1'b0, 32'h0,         32'hC,  32'hD};
    tv[15] = '{1'b0, 1'b0, 6'b000000, 5'd4,  1'b1, 32'h44,        1'b1, 32'h11, 32'h22, 5'd4,  1'b1, 32'h44,        32'h11, 32'h22};
    tv[16] = '{1'b0, 1'b0, 6'b111111, 5'd6,  1'b1, 32'h66,        1'b0, 32'h0,  32'h0,  5'd4,  1'b1, 32'h44,        32'h11, 32'h22};
    tv[17] = '{1'b0, 1'b1, 6'b111111, 5'd6,  1'b1, 32'h66,        1'b0, 32'h0,  32'h0,  5'd0,  1'b0, 32'h0,         32'h11, 32'h22};
    tv[18] = '{1'b0, 1'b0, 6'b000000, 5'd2,  1'b1, 32'h2,         1'b1, 32'h33, 32'h44, 5'd2,  1'b1, 32'h2,         32'h33, 32'h44};
    tv[19] = '{1'b1, 1'b0, 6'b111111, 5'd2,  1'b1, 32'h2,         1'b1, 32'h33, 32'h44, 5'd0,  1'b0, 32'h0,         32'h0,  32'h0};
    tv[20] = '{1'b0, 1'b0, 6'b000000, 5'd0,  1'b0, 32'h0,         1'b0, 32'h0,  32'h0,  5'd0,  1'b0, 32'h0,         32'h0,  32'h0};

    // Reset held two cycles under random MEM traffic
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'($urandom), 6'($urandom), rand_instr());
      check("rst.wb_wd",    {27'd0, wb_wd},   32'd0);
      check("rst.wb_wreg",  {31'd0, wb_wreg}, 32'd0);
      check("rst.wb_wdata", wb_wdata,         32'd0);
      check("rst.hi_o",     hi_o,             32'd0);
      check("rst.lo_o",     lo_o,             32'd0);
    end

    // Directed sequence, rows are consecutive cycles
    for (int i = 0; i < 21; i++) begin
      in = '{wd: tv[i].wd, wreg: tv[i].wreg, wdata: tv[i].wdata,
             whilo: tv[i].whilo, hi: tv[i].hi, lo: tv[i].lo};
      step(tv[i].rst, tv[i].flush, tv[i].stall, in);
      check($sformatf("vec%0d.wb_wd", i),    {27'd0, wb_wd},   {27'd0, tv[i].e_wd});
      check($sformatf("vec%0d.wb_wreg", i),  {31'd0, wb_wreg}, {31'd0, tv[i].e_wreg});
      check($sformatf("vec%0d.wb_wdata", i), wb_wdata,         tv[i].e_wdata);
      check($sformatf("vec%0d.hi_o", i),     hi_o,             tv[i].e_hi);
      check($sformatf("vec%0d.lo_o", i),     lo_o,             tv[i].e_lo);
    end

    // Held WB with a pending HI/LO write, then release with a new MEM op
    step(1'b0, 1'b0, 6'b000000, '{wd: 5'd12, wreg: 1'b1, wdata: 32'hC0DE, whilo: 1'b1, hi: 32'h5A5A, lo: 32'hA5A5});
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 6'b111111, rand_instr());
      check_model("hold");
      check("hold.hi_o.value", hi_o, 32'h5A5A);
    end
    step(1'b0, 1'b0, 6'b000000, '{wd: 5'd13, wreg: 1'b1, wdata: 32'hBEEF, whilo: 1'b0, hi: 32'h0, lo: 32'h0});
    check("release.wb_wdata", wb_wdata, 32'hBEEF);
    check("release.hi_o",     hi_o,     32'h5A5A);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: s = 6'b000000;
        1: s = 6'b011111;
        2: s = 6'b111111;
        3: s = 6'b001111;
        4: s = 6'b010000;
        default: s = 6'b100000;
      endcase
      step($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0, s, rand_instr());
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
